uart_fifo_tx: RTL and testbench

- Byte transmitter that drains the 8-entry byte FIFO from its read side and serializes each byte as 8N1 async frames on a single line.
- A burst is the set of bytes sent between tx_start and FIFO empty.
- At burst start it snapshots the FIFO read pointer via the store strobe. A later retry rewinds the pointer with the revert strobe, so the whole burst can be resent after a remote NAK.
- Sits between the APB-side FIFO writer and the chip pad.

---
 rtl/uart_fifo_tx.sv | 159 +++++++++++++++
 tb/tb_uart_fifo_tx.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_fifo_tx
// Function : Drains a byte FIFO and sends each byte as an 8N1 serial frame,
//            snapshotting the read pointer per burst so the burst can be resent.
// Revision : 1.0
// ============================================================================
module uart_fifo_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic       retry,
    input  logic       abort,
    input  logic [7:0] fifo_r_data,
    input  logic       fifo_empty,
    output logic       fifo_r_enable,
    output logic       fifo_store_r_ptr,
    output logic       fifo_revert_r_ptr,
    output logic       tx_out,
    output logic       busy,
    output logic       done,
    output logic [7:0] bytes_sent
);

    localparam logic [2:0]  S_IDLE     = 3'd0;
    localparam logic [2:0]  S_LOAD     = 3'd1;
    localparam logic [2:0]  S_START    = 3'd2;
    localparam logic [2:0]  S_DATA     = 3'd3;
    localparam logic [2:0]  S_STOP     = 3'd4;
    localparam logic [15:0] C_BIT_LAST = 16'(CLKS_PER_BIT - 1);

    logic [2:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  bytes_q, bytes_d;
    logic        done_q, done_d;
    logic        bit_end;

    assign bit_end = (cnt_q == C_BIT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 16'd0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            bytes_q <= 8'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            bytes_q <= bytes_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        bytes_d = bytes_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = 16'd0;
                bit_d = 3'd0;
                // retry wins over a simultaneous tx_start
                if (!retry && tx_start) begin
                    bytes_d = 8'd0;
                    if (fifo_empty) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                shift_d = fifo_r_data;
                if (bytes_q != 8'hFF) begin
                    bytes_d = bytes_q + 8'd1;
                end
                cnt_d   = 16'd0;
                bit_d   = 3'd0;
                state_d = S_START;
            end
            S_START: begin
                if (bit_end) begin
                    cnt_d   = 16'd0;
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d   = 16'd0;
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    cnt_d = 16'd0;
                    if (fifo_empty) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // abort leaves the LOAD-cycle shift/count updates intact since the pop happens anyway
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
            cnt_d   = 16'd0;
            bit_d   = 3'd0;
        end
    end

    always_comb begin
        fifo_r_enable     = (state_q == S_LOAD);
        fifo_store_r_ptr  = 1'b0;
        fifo_revert_r_ptr = 1'b0;
        tx_out            = 1'b1;
        case (state_q)
            S_IDLE: begin
                if (!rst) begin
                    fifo_revert_r_ptr = retry;
                    fifo_store_r_ptr  = !retry && tx_start && !fifo_empty;
                end
            end
            S_START: tx_out = 1'b0;
            S_DATA:  tx_out = shift_q[0];
            default: tx_out = 1'b1;
        endcase
    end

    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;
    assign bytes_sent = bytes_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_fifo_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_fifo_tx
// Function : Randomized scoreboard bench for uart_fifo_tx with a FIFO model
//            and a line-sampling receiver.
// Revision : 1.0
// ============================================================================
module tb_uart_fifo_tx;

    localparam int CPB    = 4;
    localparam int PERIOD = 10 * CPB + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tx_start = 1'b0;
    logic       retry = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] fifo_r_data;
    logic       fifo_empty;
    logic       fifo_r_enable;
    logic       fifo_store_r_ptr;
    logic       fifo_revert_r_ptr;
    logic       tx_out;
    logic       busy;
    logic       done;
    logic [7:0] bytes_sent;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] exp_q[$];
    logic [7:0] pending_q[$];
    logic [7:0] burst_q[$];

    uart_fifo_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk               (clk),
        .rst               (rst),
        .tx_start          (tx_start),
        .retry             (retry),
        .abort             (abort),
        .fifo_r_data       (fifo_r_data),
        .fifo_empty        (fifo_empty),
        .fifo_r_enable     (fifo_r_enable),
        .fifo_store_r_ptr  (fifo_store_r_ptr),
        .fifo_revert_r_ptr (fifo_revert_r_ptr),
        .tx_out            (tx_out),
        .busy              (busy),
        .done              (done),
        .bytes_sent        (bytes_sent)
    );

    always #5 clk = ~clk;

    // 8-entry FIFO with a saved read pointer
    logic [7:0] mem [8];
    logic [3:0] wr_ptr    = 4'd0;
    logic [3:0] rd_ptr    = 4'd0;
    logic [3:0] saved_ptr = 4'd0;

    assign fifo_empty  = (rd_ptr == wr_ptr);
    assign fifo_r_data = mem[rd_ptr[2:0]];

    always @(posedge clk) begin
        if (fifo_r_enable) rd_ptr <= rd_ptr + 4'd1;
        else if (fifo_revert_r_ptr) rd_ptr <= saved_ptr;
        if (fifo_store_r_ptr) saved_ptr <= rd_ptr;
    end

    task automatic check(input string name, input int act, input int expv);
        vectors++;
        if (act != expv) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic write_byte(input logic [7:0] b, input bit in_burst);
        mem[wr_ptr[2:0]] = b;
        wr_ptr = wr_ptr + 4'd1;
        exp_q.push_back(b);
        if (in_burst) burst_q.push_back(b);
        else pending_q.push_back(b);
    endtask

    // Receiver: samples mid-bit; frames cut short by busy dropping are discarded
    logic [7:0] mon_b;
    logic       mon_abort;
    logic [7:0] mon_e;
    initial begin
        forever begin
            @(negedge clk);
            if (tx_out === 1'b0) begin
                mon_abort = 1'b0;
                repeat (CPB / 2) @(negedge clk);
                if (busy !== 1'b1) mon_abort = 1'b1;
                else check("start_bit", int'(tx_out), 0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    if (busy !== 1'b1) mon_abort = 1'b1;
                    mon_b[i] = tx_out;
                end
                repeat (CPB) @(negedge clk);
                if (busy !== 1'b1) mon_abort = 1'b1;
                if (!mon_abort) begin
                    check("stop_bit", int'(tx_out), 1);
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL rx_unexpected: got 0x%0h, expected no frame", mon_b);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("rx_byte", int'(mon_b), int'(mon_e));
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && (fifo_r_enable || fifo_store_r_ptr || fifo_revert_r_ptr))
            check("strobe_excl", int'(fifo_r_enable) + int'(fifo_store_r_ptr)
                  + int'(fifo_revert_r_ptr), 1);
    end

    // Runs one burst over the pending bytes, checking strobes, line and completion per cycle
    task automatic run_burst(input bit extra);
        int nb, pops, dones, k, off, expl;
        logic [9:0] fr;
        burst_q = pending_q;
        pending_q.delete();
        nb = burst_q.size();
        @(posedge clk); #1 tx_start = 1'b1;
        @(negedge clk);
        check("store_c0", int'(fifo_store_r_ptr), 1);
        check("ren_c0", int'(fifo_r_enable), 0);
        @(posedge clk); #1 tx_start = 1'b0;
        pops  = 0;
        dones = 0;
        for (int c = 1; c <= PERIOD * nb + 4; c++) begin
            @(negedge clk);
            k   = (c - 1) / PERIOD;
            off = (c - 1) % PERIOD;
            if (k >= nb || off == 0) begin
                expl = 1;
            end else begin
                fr   = {1'b1, burst_q[k], 1'b0};
                expl = int'(fr[(off - 1) / CPB]);
            end
            check("line", int'(tx_out), expl);
            if (fifo_r_enable) begin
                check("pop_cycle", c, 1 + PERIOD * pops);
                pops++;
            end
            if (done) begin
                check("done_cycle", c, 1 + PERIOD * nb);
                dones++;
            end
            if (extra && c == 20 && nb < 8) begin
                write_byte(8'($urandom_range(0, 255)), 1'b1);
                nb++;
            end
        end
        check("pop_count", pops, nb);
        check("done_count", dones, 1);
        check("bytes_sent", int'(bytes_sent), nb);
        check("busy_end", int'(busy), 0);
    endtask

    task automatic do_retry(input bit with_start);
        @(posedge clk); #1 retry = 1'b1; tx_start = with_start;
        @(negedge clk);
        check("revert", int'(fifo_revert_r_ptr), 1);
        check("store_on_retry", int'(fifo_store_r_ptr), 0);
        check("ren_on_retry", int'(fifo_r_enable), 0);
        @(posedge clk); #1 retry = 1'b0; tx_start = 1'b0;
        @(negedge clk);
        check("revert_len", int'(fifo_revert_r_ptr), 0);
        check("busy_after_retry", int'(busy), 0);
        check("done_after_retry", int'(done), 0);
        foreach (burst_q[i]) begin
            pending_q.push_back(burst_q[i]);
            exp_q.push_back(burst_q[i]);
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 8'h00;
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", int'(tx_out), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_bytes", int'(bytes_sent), 0);
        check("rst_strobes", int'({fifo_r_enable, fifo_store_r_ptr, fifo_revert_r_ptr}), 0);
        rst = 1'b0;

        // asynchronous reset in the middle of a data bit
        write_byte(8'h3C, 1'b0);
        pending_q.delete();
        @(posedge clk); #1 tx_start = 1'b1;
        @(posedge clk); #1 tx_start = 1'b0;
        repeat (12) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_tx", int'(tx_out), 1);
        check("arst_busy", int'(busy), 0);
        check("arst_bytes", int'(bytes_sent), 0);
        check("arst_strobes", int'({fifo_r_enable, fifo_store_r_ptr, fifo_revert_r_ptr}), 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("arst_idle", int'(busy), 0);
        repeat (50) @(posedge clk);
        exp_q.delete();

        write_byte(8'hA5, 1'b0);
        run_burst(1'b0);

        write_byte(8'h01, 1'b0);
        write_byte(8'h80, 1'b0);
        write_byte(8'hFF, 1'b0);
        run_burst(1'b0);

        do_retry(1'b0);
        run_burst(1'b0);
        do_retry(1'b1);
        run_burst(1'b0);

        // start with nothing queued
        @(posedge clk); #1 tx_start = 1'b1;
        @(negedge clk);
        check("empty_strobes", int'({fifo_r_enable, fifo_store_r_ptr, fifo_revert_r_ptr}), 0);
        @(posedge clk); #1 tx_start = 1'b0;
        @(negedge clk);
        check("empty_done", int'(done), 1);
        check("empty_bytes", int'(bytes_sent), 0);
        check("empty_busy", int'(busy), 0);
        check("empty_tx", int'(tx_out), 1);
        @(negedge clk);
        check("empty_done_pulse", int'(done), 0);

        for (int r = 0; r < 8; r++) begin
            int n;
            n = $urandom_range(1, 6);
            for (int j = 0; j < n; j++) write_byte(8'($urandom_range(0, 255)), 1'b0);
            run_burst(1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) begin
                do_retry(1'b0);
                run_burst(1'b0);
            end
        end

        // abort during bit 3 of the second byte
        write_byte(8'h11, 1'b0);
        write_byte(8'h22, 1'b0);
        write_byte(8'h33, 1'b0);
        pending_q.delete();
        @(posedge clk); #1 tx_start = 1'b1;
        @(posedge clk); #1 tx_start = 1'b0;
        repeat (59) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        check("abort_tx", int'(tx_out), 1);
        check("abort_busy", int'(busy), 0);
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            check("abort_no_done", int'(done), 0);
            check("abort_no_pop", int'(fifo_r_enable), 0);
        end
        check("abort_bytes", int'(bytes_sent), 2);
        check("abort_rx_left", exp_q.size(), 2);
        exp_q.delete();

        repeat (10) @(posedge clk);
        check("leftover_frames", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
